// File: rtl/serial_alu_pkg.sv
// Shared opcode constants and FSM state encoding for the slice-serial ALU.
package serial_alu_pkg;

  localparam logic [1:0] OP_AND = 2'b00;
  localparam logic [1:0] OP_OR  = 2'b01;
  localparam logic [1:0] OP_ADD = 2'b10;
  localparam logic [1:0] OP_SUB = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  // ADD and SUB share the opcode MSB; they are the only ops that carry.
  function automatic logic is_arith(input logic [1:0] op);
    return op[1];
  endfunction

endpackage

// File: rtl/alu_slice.sv
// Combinational SLICE-bit ALU cell: AND, OR, ADD (a+b+c), SUB (a+~b+c).
// With SERIAL_ALU_OVF_EN defined it also exports the carry into its MSB.
module alu_slice
  import serial_alu_pkg::*;
#(
  parameter int SLICE = 4
) (
  input  logic [SLICE-1:0] a,
  input  logic [SLICE-1:0] b,
  input  logic             c,
  input  logic [1:0]       aluctr,
  output logic [SLICE-1:0] d,
  output logic             e
`ifdef SERIAL_ALU_OVF_EN
  ,
  output logic             cmsb
`endif
);

  logic [SLICE-1:0] bb;
  logic [SLICE:0]   sum;

  always_comb begin
    bb  = (aluctr == OP_SUB) ? ~b : b;
    sum = {1'b0, a} + {1'b0, bb} + {{SLICE{1'b0}}, c};
    d   = '0;
    e   = 1'b0;
    case (aluctr)
      OP_AND:  d = a & b;
      OP_OR:   d = a | b;
      default: begin
        d = sum[SLICE-1:0];
        e = sum[SLICE];
      end
    endcase
  end

`ifdef SERIAL_ALU_OVF_EN
  // Sum bit is a^b^carry-in, so xoring the operands back out leaves the carry.
  assign cmsb = is_arith(aluctr) & (sum[SLICE-1] ^ a[SLICE-1] ^ bb[SLICE-1]);
`endif

endmodule

// File: rtl/serial_alu.sv
// Slice-serial WIDTH-bit ALU, SLICE bits per clock, LSB slice first, start/busy/done.
// Define SERIAL_ALU_OVF_EN to add the signed-overflow output ovf.
module serial_alu
  import serial_alu_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int SLICE = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             c,
  input  logic [1:0]       aluctr,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] d,
  output logic             e
`ifdef SERIAL_ALU_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int NSLICE = WIDTH / SLICE;
  localparam int IW     = (NSLICE > 1) ? $clog2(NSLICE) : 1;
  localparam logic [IW-1:0] LAST = IW'(NSLICE - 1);

  state_t           state, next_state;
  logic [IW-1:0]    idx;
  logic [WIDTH-1:0] a_sh, b_sh, res, res_next;
  logic [1:0]       op;
  logic             carry;
  logic [SLICE-1:0] slice_d;
  logic             slice_e;
  logic             accept;
`ifdef SERIAL_ALU_OVF_EN
  logic             slice_cmsb;
`endif

  alu_slice #(.SLICE(SLICE)) u_slice (
    .a      (a_sh[SLICE-1:0]),
    .b      (b_sh[SLICE-1:0]),
    .c      (carry),
    .aluctr (op),
    .d      (slice_d),
    .e      (slice_e)
`ifdef SERIAL_ALU_OVF_EN
    ,
    .cmsb   (slice_cmsb)
`endif
  );

  // DONE accepts a new start just like IDLE, giving back-to-back operation.
  assign accept   = start && (state != RUN);
  assign res_next = (res >> SLICE) | (WIDTH'(slice_d) << (WIDTH - SLICE));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= IDLE;
    else        state <= next_state;
  end

  always_comb begin
    next_state = state;
    case (state)
      IDLE:    if (start) next_state = RUN;
      RUN:     if (idx == LAST) next_state = DONE;
      DONE:    next_state = start ? RUN : IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_comb begin
    busy = (state == RUN);
    done = (state == DONE);
  end

  // Operands shift right so the slice always sees the low bits; results enter from the top.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_sh  <= '0;
      b_sh  <= '0;
      res   <= '0;
      op    <= OP_AND;
      carry <= 1'b0;
      idx   <= '0;
      d     <= '0;
      e     <= 1'b0;
`ifdef SERIAL_ALU_OVF_EN
      ovf   <= 1'b0;
`endif
    end else if (accept) begin
      a_sh  <= a;
      b_sh  <= b;
      op    <= aluctr;
      carry <= is_arith(aluctr) ? c : 1'b0;
      idx   <= '0;
    end else if (state == RUN) begin
      a_sh  <= a_sh >> SLICE;
      b_sh  <= b_sh >> SLICE;
      res   <= res_next;
      carry <= slice_e;
      idx   <= idx + IW'(1);
      if (idx == LAST) begin
        d   <= res_next;
        e   <= slice_e;
`ifdef SERIAL_ALU_OVF_EN
        ovf <= slice_cmsb ^ slice_e;
`endif
      end
    end
  end

endmodule

// File: tb/tb_serial_alu.sv
// Self-checking bench for serial_alu: table vectors, random vectors against a
// plain-arithmetic model, and hand-written handshake/reset sequences.
module tb_serial_alu;
  import serial_alu_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst_n, start, c, busy, done, e;
  logic [15:0] a, b, d;
  logic [1:0]  aluctr;
  logic        start8, c8, busy8, done8, e8;
  logic [7:0]  a8, b8, d8;
  logic [1:0]  aluctr8;
`ifdef SERIAL_ALU_OVF_EN
  logic        ovf, ovf8;
`endif

  int total = 0;
  int bad   = 0;

  serial_alu #(.WIDTH(16), .SLICE(4)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b), .c(c),
    .aluctr(aluctr), .busy(busy), .done(done), .d(d), .e(e)
`ifdef SERIAL_ALU_OVF_EN
    , .ovf(ovf)
`endif
  );

  serial_alu #(.WIDTH(8), .SLICE(8)) dut8 (
    .clk(clk), .rst_n(rst_n), .start(start8), .a(a8), .b(b8), .c(c8),
    .aluctr(aluctr8), .busy(busy8), .done(done8), .d(d8), .e(e8)
`ifdef SERIAL_ALU_OVF_EN
    , .ovf(ovf8)
`endif
  );

  typedef struct {
    string       name;
    logic [15:0] a;
    logic [15:0] b;
    logic        c;
    logic [1:0]  op;
    logic [15:0] exp_d;
    logic        exp_e;
    logic        exp_ovf;
  } vec_t;

  vec_t vecs[$];

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("[TB] FAIL %s: got=0x%0h expected=0x%0h", name, got, want);
    end
  endtask

  // Reference: returns {ovf, e, d} from whole-word integer arithmetic.
  function automatic logic [17:0] model(input logic [15:0] x, input logic [15:0] y,
                                        input logic ci, input logic [1:0] op);
    logic [15:0] yy;
    logic [16:0] u;
    int          s;
    if (op == OP_AND) return {2'b00, x & y};
    if (op == OP_OR)  return {2'b00, x | y};
    yy = (op == OP_SUB) ? ~y : y;
    u  = {1'b0, x} + {1'b0, yy} + {16'd0, ci};
    s  = int'($signed(x)) + int'($signed(yy)) + (ci ? 1 : 0);
    return {(s > 32767) || (s < -32768), u[16], u[15:0]};
  endfunction

  task automatic applyStimulus(input logic [15:0] x, input logic [15:0] y, input logic ci,
                               input logic [1:0] op, output int lat, output int busy_n);
    @(negedge clk);
    a = x; b = y; c = ci; aluctr = op; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start  = 1'b0;
    lat    = 0;
    busy_n = 0;
    while (!done && lat < 40) begin
      if (busy) busy_n++;
      @(negedge clk);
      lat++;
    end
  endtask

  task automatic checkOutput(input string name, input logic [15:0] wd, input logic we,
                             input logic wovf);
    check({name, " d"}, 32'(d), 32'(wd));
    check({name, " e"}, 32'(e), 32'(we));
`ifdef SERIAL_ALU_OVF_EN
    check({name, " ovf"}, 32'(ovf), 32'(wovf));
`else
    if (wovf === 1'bx) $display("[TB] unexpected unknown ovf in %s", name);
`endif
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    int          lat, busy_n, gap, pulses;
    logic [15:0] ra, rb, held;
    logic [1:0]  rop;
    logic        rc;
    logic [17:0] m;

    rst_n = 1'b0; start = 1'b0; a = '0; b = '0; c = 1'b0; aluctr = OP_AND;
    start8 = 1'b0; a8 = '0; b8 = '0; c8 = 1'b0; aluctr8 = OP_AND;

    vecs.push_back('{"add wrap",  16'hFFFF, 16'h0001, 1'b0, OP_ADD, 16'h0000, 1'b1, 1'b0});
    vecs.push_back('{"sub neg",   16'h0005, 16'h0007, 1'b1, OP_SUB, 16'hFFFE, 1'b0, 1'b0});
    vecs.push_back('{"sub ovf",   16'h8000, 16'h0001, 1'b1, OP_SUB, 16'h7FFF, 1'b1, 1'b1});
    vecs.push_back('{"and",       16'hF0F0, 16'hFF00, 1'b1, OP_AND, 16'hF000, 1'b0, 1'b0});
    vecs.push_back('{"or",        16'hF0F0, 16'hFF00, 1'b1, OP_OR,  16'hFFF0, 1'b0, 1'b0});
    vecs.push_back('{"add plain", 16'h1234, 16'h1111, 1'b0, OP_ADD, 16'h2345, 1'b0, 1'b0});
    vecs.push_back('{"add ovf",   16'h7FFF, 16'h0001, 1'b0, OP_ADD, 16'h8000, 1'b0, 1'b1});
    vecs.push_back('{"add cin",   16'h00FF, 16'h0000, 1'b1, OP_ADD, 16'h0100, 1'b0, 1'b0});
    for (int i = 0; i < 10; i++) begin
      ra = 16'($urandom); rb = 16'($urandom); rc = 1'($urandom); rop = 2'($urandom);
      m  = model(ra, rb, rc, rop);
      vecs.push_back('{$sformatf("rand%0d", i), ra, rb, rc, rop, m[15:0], m[16], m[17]});
    end

    repeat (2) @(negedge clk);
    check("reset busy", 32'(busy), 32'd0);
    check("reset done", 32'(done), 32'd0);
    check("reset d",    32'(d),    32'd0);
    check("reset e",    32'(e),    32'd0);
    rst_n = 1'b1;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].a, vecs[i].b, vecs[i].c, vecs[i].op, lat, busy_n);
      check({vecs[i].name, " latency"}, 32'(lat), 32'd4);
      check({vecs[i].name, " busy cycles"}, 32'(busy_n), 32'd4);
      checkOutput(vecs[i].name, vecs[i].exp_d, vecs[i].exp_e, vecs[i].exp_ovf);
    end

    // AND then OR started in the DONE cycle of the AND.
    applyStimulus(16'hF0F0, 16'hFF00, 1'b0, OP_AND, lat, busy_n);
    checkOutput("b2b and", 16'hF000, 1'b0, 1'b0);
    a = 16'hF0F0; b = 16'hFF00; aluctr = OP_OR; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    gap = 1;
    while (!done && gap < 40) begin
      @(negedge clk);
      gap++;
    end
    check("b2b gap", 32'(gap), 32'd5);
    checkOutput("b2b or", 16'hFFF0, 1'b0, 1'b0);

    // A start during the second busy cycle must be ignored.
    @(negedge clk);
    a = 16'h1234; b = 16'h1111; c = 1'b0; aluctr = OP_ADD; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    a = 16'hFFFF; b = 16'hFFFF; c = 1'b1; aluctr = OP_AND; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pulses = 0;
    held   = '0;
    for (int i = 0; i < 12; i++) begin
      if (done) begin
        pulses++;
        held = d;
      end
      @(negedge clk);
    end
    check("ignored start pulses", 32'(pulses), 32'd1);
    check("ignored start d", 32'(held), 32'h2345);
    check("held d", 32'(d), 32'h2345);

    // Asynchronous reset in the middle of a run.
    @(negedge clk);
    a = 16'h0F0F; b = 16'h0101; c = 1'b0; aluctr = OP_ADD; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("midrun rst busy", 32'(busy), 32'd0);
    check("midrun rst done", 32'(done), 32'd0);
    check("midrun rst d",    32'(d),    32'd0);
    check("midrun rst e",    32'(e),    32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(16'hFFF0, 16'h0020, 1'b0, OP_ADD, lat, busy_n);
    check("post rst latency", 32'(lat), 32'd4);
    checkOutput("post rst", 16'h0010, 1'b1, 1'b0);

    // Single-slice instance: 8-bit operation finishes one edge after acceptance.
    @(negedge clk);
    a8 = 8'h80; b8 = 8'h80; c8 = 1'b1; aluctr8 = OP_ADD; start8 = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start8 = 1'b0;
    lat = 0;
    while (!done8 && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check("w8 latency", 32'(lat), 32'd1);
    check("w8 d", 32'(d8), 32'h01);
    check("w8 e", 32'(e8), 32'd1);
`ifdef SERIAL_ALU_OVF_EN
    check("w8 ovf", 32'(ovf8), 32'd1);
`endif
    @(negedge clk);
    check("w8 done pulse", 32'(done8), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
